// File: rtl/keypad_digit_display.sv
// keypad_digit_display
// Decodes one-hot row/column key events from keypad_scan into hex values,
// keeps a two-digit history (newest on the right), and time-multiplexes
// both digits onto a dual common-anode seven-segment display with a
// blanking gap between digits to suppress ghosting.
//
// Optional feature macro: KEYPAD_LEADING_BLANK_EN
//   When defined, the left digit stays dark until two keys have been
//   accepted since reset, so the power-on "0" never shows on the left.
//   When undefined, the left digit is always lit during its phase.

module keypad_digit_display #(
    parameter int MUX_CYCLES   = 2400,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic [3:0] col,
    input  logic       num_new,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_right,
    output logic [3:0] digit_left
);

    localparam int MAX_CYCLES = (MUX_CYCLES > BLANK_CYCLES) ? MUX_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] MUX_LOAD   = CNT_W'(MUX_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {
        BLANK_LR = 2'd0,
        SHOW_R   = 2'd1,
        BLANK_RL = 2'd2,
        SHOW_L   = 2'd3
    } state_t;

    // True when exactly one bit of a 4-bit vector is set.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Bit position of a one-hot vector; only meaningful when is_onehot().
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Keypad layout, indexed by {row, column}.
    function automatic logic [3:0] key_decode(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return 4'hE;
            4'hD: return 4'h0;
            4'hE: return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyphs for hex 0-F.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_digit_right;
    logic [3:0]       r_digit_left;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic [6:0]       w_seg_next;
    logic [1:0]       w_an_next;
    logic             w_accept;
    logic [3:0]       w_key;
    logic             w_left_en;

    // A press counts only if both row and column are unambiguous.
    assign w_accept = num_new & is_onehot(rows) & is_onehot(col);
    assign w_key    = key_decode(onehot_idx(rows), onehot_idx(col));

    // Shift the accepted key into the two-digit history.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the left digit must capture the old right digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit_right <= 4'h0;
            r_digit_left  <= 4'h0;
        end else if (w_accept) begin
            r_digit_left  <= r_digit_right;
            r_digit_right <= w_key;
        end
    end

`ifdef KEYPAD_LEADING_BLANK_EN
    logic [1:0] r_press_cnt;

    // Saturating count of accepted presses; the left digit lights from 2 on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_press_cnt <= 2'd0;
        end else if (w_accept && (r_press_cnt != 2'd3)) begin
            r_press_cnt <= r_press_cnt + 2'd1;
        end
    end

    assign w_left_en = r_press_cnt[1];
`else
    assign w_left_en = 1'b1;
`endif

    // State register and shared phase down-counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BLANK_LR;
            r_cnt   <= BLANK_LOAD;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: count down, advance and reload when the counter hits zero.
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
            case (r_state)
                BLANK_LR: begin w_state_next = SHOW_R;   w_cnt_next = MUX_LOAD;   end
                SHOW_R:   begin w_state_next = BLANK_RL; w_cnt_next = BLANK_LOAD; end
                BLANK_RL: begin w_state_next = SHOW_L;   w_cnt_next = MUX_LOAD;   end
                default:  begin w_state_next = BLANK_LR; w_cnt_next = BLANK_LOAD; end
            endcase
        end
    end

    // Output decode: anode and glyph for the current phase.
    always_comb begin
        w_an_next  = 2'b11;
        w_seg_next = SEG_OFF;
        case (r_state)
            SHOW_R: begin
                w_an_next  = 2'b10;
                w_seg_next = seg_encode(r_digit_right);
            end
            SHOW_L: begin
                if (w_left_en) begin
                    w_an_next  = 2'b01;
                    w_seg_next = seg_encode(r_digit_left);
                end
            end
            default: ;
        endcase
    end

    // Register display drive so the pins are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 2'b11;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign digit_right = r_digit_right;
    assign digit_left  = r_digit_left;

endmodule

// File: tb/tb_keypad_digit_display.sv
// Self-checking bench for keypad_digit_display. A cycle-indexed reference
// model (refresh phase from the edge count since reset, digit history as
// plain variables) predicts every output. Honours KEYPAD_LEADING_BLANK_EN.

module tb_keypad_digit_display;

    localparam int M = 5;
    localparam int B = 3;
    localparam int P = 2 * (M + B);

`ifdef KEYPAD_LEADING_BLANK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows = 4'd0;
    logic [3:0] col = 4'd0;
    logic       num_new = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_right;
    logic [3:0] digit_left;

    int n_checks = 0;
    int n_errors = 0;

    keypad_digit_display #(.MUX_CYCLES(M), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .rows(rows), .col(col), .num_new(num_new),
        .seg(seg), .an(an), .digit_right(digit_right), .digit_left(digit_left)
    );

    always #5 clk = ~clk;

    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    logic [6:0] segtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state: edges since reset release, digits after the
    // latest edge, and their values one edge earlier (what the registered
    // display is showing now).
    int         m_k = 0;
    logic [3:0] m_left = 4'd0, m_right = 4'd0, m_pl = 4'd0, m_pr = 4'd0;
    int         m_cnt = 0, m_pcnt = 0;

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k <= 0; m_left <= 4'd0; m_right <= 4'd0; m_pl <= 4'd0; m_pr <= 4'd0;
            m_cnt <= 0; m_pcnt <= 0;
        end else begin
            m_pl   <= m_left;
            m_pr   <= m_right;
            m_pcnt <= m_cnt;
            if (num_new && $countones(rows) == 1 && $countones(col) == 1) begin
                m_left  <= m_right;
                m_right <= 4'(keymap[idx_of(rows)][idx_of(col)]);
                m_cnt   <= (m_cnt < 3) ? m_cnt + 1 : 3;
            end
            m_k <= m_k + 1;
        end
    end

    function automatic logic [1:0] exp_an();
        int p;
        if (m_k == 0) return 2'b11;
        p = (m_k - 1) % P;
        if (p < B) return 2'b11;
        if (p < B + M) return 2'b10;
        if (p < 2 * B + M) return 2'b11;
        return (LB && m_pcnt < 2) ? 2'b11 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg();
        int p;
        if (m_k == 0) return 7'b1111111;
        p = (m_k - 1) % P;
        if (p >= B && p < B + M) return segtab[m_pr];
        if (p >= 2 * B + M) return (LB && m_pcnt < 2) ? 7'b1111111 : segtab[m_pl];
        return 7'b1111111;
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] c, input logic n);
        rows = r; col = c; num_new = n;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== 2'b11) begin n_errors++; $display("FAIL reset_an: got %b want 11", an); end
            n_checks++;
            if (seg !== 7'b1111111) begin n_errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
            n_checks++;
            if ({digit_left, digit_right} !== 8'h00) begin
                n_errors++; $display("FAIL reset_digits: got %h%h want 00", digit_left, digit_right);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= B + 1; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== ((i == B + 1) ? 2'b10 : 2'b11)) begin
                n_errors++; $display("FAIL first_show_an: cycle %0d got %b", i, an);
            end
            n_checks++;
            if (seg !== ((i == B + 1) ? 7'b1000000 : 7'b1111111)) begin
                n_errors++; $display("FAIL first_show_seg: cycle %0d got %b", i, seg);
            end
        end
    endtask

    task automatic test_capture();
        bit found;
        drive(4'b0001, 4'b0010, 1'b1);
        @(negedge clk);
        drive(4'd0, 4'd0, 1'b0);
        n_checks++;
        if ({digit_left, digit_right} !== 8'h02) begin
            n_errors++; $display("FAIL capture_first: got %h%h want 02", digit_left, digit_right);
        end
        drive(4'b0100, 4'b1000, 1'b1);
        @(negedge clk);
        drive(4'd0, 4'd0, 1'b0);
        n_checks++;
        if ({digit_left, digit_right} !== 8'h2C) begin
            n_errors++; $display("FAIL capture_second: got %h%h want 2c", digit_left, digit_right);
        end
        @(negedge clk);
        found = 0;
        for (int i = 0; i < P && !found; i++) begin
            @(negedge clk);
            if (an == 2'b10) begin
                found = 1;
                n_checks++;
                if (seg !== 7'b1000110) begin n_errors++; $display("FAIL capture_seg_c: got %b want 1000110", seg); end
            end
        end
        if (!found) begin n_checks++; n_errors++; $display("FAIL capture_timeout: SHOW_R never seen"); end
    endtask

    task automatic test_invalid();
        logic [3:0] bad_rows [4] = '{4'b0001, 4'b0001, 4'b0011, 4'b0000};
        logic [3:0] bad_cols [4] = '{4'b0110, 4'b0000, 4'b0001, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            drive(bad_rows[i], bad_cols[i], 1'b1);
            @(negedge clk);
            drive(4'd0, 4'd0, 1'b0);
            n_checks++;
            if ({digit_left, digit_right} !== 8'h2C) begin
                n_errors++; $display("FAIL invalid_%0d: got %h%h want 2c", i, digit_left, digit_right);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(4'b0010, 4'b0010, 1'b1);   // 5
        @(negedge clk);
        drive(4'b0100, 4'b0100, 1'b1);   // 9
        @(negedge clk);
        drive(4'd0, 4'd0, 1'b0);
        n_checks++;
        if ({digit_left, digit_right} !== 8'h59) begin
            n_errors++; $display("FAIL back_to_back: got %h%h want 59", digit_left, digit_right);
        end
    endtask

    task automatic test_sweep();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(4'(1 << r), 4'(1 << c), 1'b1);
                @(negedge clk);
                drive(4'd0, 4'd0, 1'b0);
                n_checks++;
                if (digit_right !== 4'(keymap[r][c])) begin
                    n_errors++; $display("FAIL sweep_key r%0d c%0d: got %h want %h", r, c, digit_right, keymap[r][c]);
                end
                for (int i = 0; i < P; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if (an !== exp_an() || seg !== exp_seg()) begin
                        n_errors++;
                        $display("FAIL sweep_display r%0d c%0d: an=%b seg=%b want an=%b seg=%b",
                                 r, c, an, seg, exp_an(), exp_seg());
                    end
                end
            end
        end
    endtask

    task automatic test_refresh();
        logic [1:0] prev_an;
        int run;
        bit first;
        prev_an = 2'b11; run = 0; first = 1;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            n_checks++;
            if (an === 2'b00 || an !== exp_an()) begin
                n_errors++; $display("FAIL refresh_an: cycle %0d got %b want %b", i, an, exp_an());
            end
            if (i == 0) begin
                prev_an = an; run = 1;
            end else if (an == prev_an) begin
                run++;
            end else begin
                if (!first) begin
                    n_checks++;
                    if (run !== ((prev_an == 2'b11) ? B : M)) begin
                        n_errors++; $display("FAIL refresh_len: an=%b lasted %0d", prev_an, run);
                    end
                end
                first = 0; prev_an = an; run = 1;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r, c;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            drive(r, c, 1'($urandom_range(0, 1)));
            @(negedge clk);
            n_checks++;
            if (digit_right !== m_right || digit_left !== m_left) begin
                n_errors++; $display("FAIL random_digits %0d: got %h%h want %h%h", i, digit_left, digit_right, m_left, m_right);
            end
            n_checks++;
            if (an !== exp_an() || seg !== exp_seg()) begin
                n_errors++; $display("FAIL random_display %0d: an=%b seg=%b want an=%b seg=%b", i, an, seg, exp_an(), exp_seg());
            end
        end
        drive(4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        bit found;
        found = 0;
        for (int i = 0; i < P && !found; i++) begin
            @(negedge clk);
            if (an == 2'b10) found = 1;
        end
        if (!found) begin n_checks++; n_errors++; $display("FAIL async_reset_timeout: SHOW_R never seen"); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (an !== 2'b11 || seg !== 7'b1111111) begin
            n_errors++; $display("FAIL async_reset_display: an=%b seg=%b want 11 1111111", an, seg);
        end
        n_checks++;
        if ({digit_left, digit_right} !== 8'h00) begin
            n_errors++; $display("FAIL async_reset_digits: got %h%h want 00", digit_left, digit_right);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_leading_blank();
        int  seen01;
        bit  saw;
        // No presses yet.
        seen01 = 0; saw = 0;
        for (int i = 0; i < P + 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an() || seg !== exp_seg()) begin
                n_errors++; $display("FAIL lead_idle %0d: an=%b seg=%b want an=%b seg=%b", i, an, seg, exp_an(), exp_seg());
            end
            if (an == 2'b01) begin seen01++; if (seg == 7'b1000000) saw = 1; end
        end
        n_checks++;
        if ((seen01 > 0) !== !LB || saw !== !LB) begin
            n_errors++; $display("FAIL lead_idle_left: lit=%0d zero_shown=%0d", seen01, saw);
        end
        // One press (key 7): left still gated when blanking is enabled.
        drive(4'b0100, 4'b0001, 1'b1);
        @(negedge clk);
        drive(4'd0, 4'd0, 1'b0);
        seen01 = 0;
        for (int i = 0; i < P + 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an() || seg !== exp_seg()) begin
                n_errors++; $display("FAIL lead_one %0d: an=%b seg=%b want an=%b seg=%b", i, an, seg, exp_an(), exp_seg());
            end
            if (an == 2'b01) seen01++;
        end
        n_checks++;
        if ((seen01 > 0) !== !LB) begin
            n_errors++; $display("FAIL lead_one_left: lit=%0d", seen01);
        end
        // Second press (key 3): left shows the first key in either build.
        drive(4'b0001, 4'b0100, 1'b1);
        @(negedge clk);
        drive(4'd0, 4'd0, 1'b0);
        saw = 0;
        for (int i = 0; i < P + 2; i++) begin
            @(negedge clk);
            if (an == 2'b01 && seg == 7'b1111000) saw = 1;
        end
        n_checks++;
        if (saw !== 1'b1) begin
            n_errors++; $display("FAIL lead_two_left: left digit 7 seen=%0d want 1", saw);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_capture();
        test_invalid();
        test_back_to_back();
        test_sweep();
        test_refresh();
        test_random();
        test_async_reset();
        test_leading_blank();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_digit_display.md
# keypad_digit_display

Downstream consumer of `keypad_scan`.
- On each `num_new` pulse, decodes the one-hot row/column pair into a hex key value.
- Shifts that value into a two-digit history: the newest key goes to the right digit, and the older key moves to the left digit.
- Time-multiplexes both digits onto a dual common-anode seven-segment display, with a blanking gap between digits to prevent ghosting.

## Interface
Parameters:
- `MUX_CYCLES`, default 2400: clock cycles each digit is lit per refresh phase; legal range ≥ 2.
- `BLANK_CYCLES`, default 16: clock cycles with both anodes off between digits; legal range ≥ 1.

Ports:
- `clk`  input  1  system clock; every register updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `rows`  input  4  one-hot row currently driven by `keypad_scan`; bit 0 = row 1.
- `col`  input  4  synchronized column sense; bit 0 = column 1.
- `num_new`  input  1  single-cycle new-key pulse from `keypad_scan`.
- `seg`  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- `an`  output  2  anode enables, active-low; bit 0 = right digit, bit 1 = left digit.
- `digit_right`  output  4  newest key value.
- `digit_left`  output  4  previous key value.

## Operation
Key map, rows × columns 1–4:
- Row 1: 1 2 3 A
- Row 2: 4 5 6 B
- Row 3: 7 8 9 C
- Row 4: E 0 F D

Capture rules:
- A press is accepted only when `num_new`=1 and both `rows` and `col` are exactly one-hot in the same cycle.
- An accepted press updates `digit_left` ← `digit_right` and `digit_right` ← decoded value.
- A `num_new` with non-one-hot `rows` or `col` (zero or multiple bits set) is ignored. Digits hold.

Display FSM, four states with one shared down-counter:
- `BLANK_LR`: `an`=11. Lasts BLANK_CYCLES, then → `SHOW_R`.
- `SHOW_R`: `an`=10, `seg`=encode(`digit_right`). Lasts MUX_CYCLES, then → `BLANK_RL`.
- `BLANK_RL`: `an`=11. Lasts BLANK_CYCLES, then → `SHOW_L`.
- `SHOW_L`: `an`=01, `seg`=encode(`digit_left`). Lasts MUX_CYCLES, then → `BLANK_LR`.
- Counter width is $clog2(max(MUX_CYCLES, BLANK_CYCLES)). It reloads to (duration−1) on entry to each state and transitions when it reaches 0.

Segment encoding, active-low {g..a}, hex 0–F:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000, A = 0001000, B = 0000011
- C = 1000110, D = 0100001, E = 0000110, F = 0001110
- `seg` is 1111111 in both blank states.

Boundary conditions:
- Reset asserted mid-operation: digits clear and the FSM returns to `BLANK_LR` immediately, independent of the clock.
- Press during a `SHOW` state: the lit digit changes on the next cycle. The FSM phase and counter are unaffected.
- Back-to-back `num_new` on consecutive cycles: each accepted pulse shifts once.

## Timing
- Reset values: `digit_left`=0, `digit_right`=0, state `BLANK_LR`, counter=BLANK_CYCLES−1, `an`=11, `seg`=1111111.
- `seg` and `an` are registered outputs: one cycle after a state or digit change.
- Capture latency: `digit_*` update on the rising edge that samples `num_new`=1, and are visible the same cycle after that edge.
- First `an`=10 appears BLANK_CYCLES+1 cycles after `reset` deasserts.
- Full refresh period: 2·(MUX_CYCLES+BLANK_CYCLES) cycles.
- `an` never has both bits low in any cycle.

## Configuration
`KEYPAD_LEADING_BLANK_EN` controls leading-digit blanking.
- Defined:
  - A 2-bit saturating accepted-press counter, cleared by reset, gates the left digit.
  - While the counter is < 2, `SHOW_L` drives `an`=11 and `seg`=1111111; the FSM timing is unchanged.
- Undefined: the counter is absent, and `SHOW_L` always lights `digit_left`, which shows 0 after reset.

## Test plan
- Reset held 3 cycles then released → `an`=11 and `seg`=1111111 during reset; first `an`=10 with `seg`=1000000 exactly BLANK_CYCLES+1 cycles after release.
- Press `rows`=0001, `col`=0010 with `num_new` pulse, then `rows`=0100, `col`=1000 → `digit_right`=2 then C, `digit_left`=0 then 2. During `SHOW_R`, `seg`=1000110.
- `num_new` with `col`=0110, and separately with `col`=0000 → digits unchanged.
- Sweep all 16 row/col pairs → `digit_right` matches the key map; `seg` matches the encoding table for every value.
- Monitor `an` over 3 full refresh periods → never 00. `SHOW` and blank durations equal MUX_CYCLES and BLANK_CYCLES exactly.
- With `KEYPAD_LEADING_BLANK_EN`: after one press, `SHOW_L` keeps `an`=11; after a second press, `an`=01 with the first key shown. Without the macro, `an`=01 showing 0 after reset.
